// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
//
// Execute-stage HI/LO unit for the MIPS multiply/divide group. It reads the
// same ID/EX operands as the ALU. It runs a 32-iteration shift-add multiply or
// restoring divide, owns the HI and LO registers, and holds the front of the
// pipeline while an operation is in flight.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   i_valid    ID/EX holds a real instruction (not a bubble)
//   i_op       latched opcode; the unit only reacts to 0x00
//   i_funct    latched funct field (sig_extended[5:0])
//   i_rs_reg   rs value: multiplicand, dividend or MTHI/MTLO source
//   i_rt_reg   rt value: multiplier or divisor
//   o_busy     iterative operation in progress
//   o_stall    hold request to the IF/ID and ID/EX latches
//   o_done     one-cycle pulse when a mult/div result lands in HI/LO
//   o_mf_data  HI for MFHI, LO for MFLO, otherwise zero
//   o_hi       HI register
//   o_lo       LO register
// -----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [5:0]        i_op,
    input  logic [5:0]        i_funct,
    input  logic [DATA_W-1:0] i_rs_reg,
    input  logic [DATA_W-1:0] i_rt_reg,
    output logic              o_busy,
    output logic              o_stall,
    output logic              o_done,
    output logic [DATA_W-1:0] o_mf_data,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [2*DATA_W-1:0] acc_q,     acc_d;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   opnd_q,    opnd_d;     // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   rs_q,      rs_d;       // original rs, returned in HI on divide by zero
    logic                is_div_q,  is_div_d;
    logic                neg_q,     neg_d;      // product / quotient sign
    logic                rem_neg_q, rem_neg_d;  // remainder follows the dividend sign
    logic                div0_q,    div0_d;
    logic                done_q,    done_d;
    logic [DATA_W-1:0]   hi_q,      hi_d;
    logic [DATA_W-1:0]   lo_q,      lo_d;

    // Instruction decode
    logic              is_rtype, is_start, op_signed, rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_mag, rt_mag;

    assign is_rtype  = i_valid && (i_op == 6'h00);
    assign is_start  = is_rtype && (i_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign op_signed = ~i_funct[0];             // MULT and DIV are the even functs
    assign rs_neg    = op_signed && i_rs_reg[DATA_W-1];
    assign rt_neg    = op_signed && i_rt_reg[DATA_W-1];
    assign rs_mag    = rs_neg ? -i_rs_reg : i_rs_reg;
    assign rt_mag    = rt_neg ? -i_rt_reg : i_rt_reg;

    // One multiply step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right, carry included.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // One restoring-divide step. The shifted partial remainder is DATA_W+1 bits
    // wide. When it is not below the divisor, the difference always fits in
    // DATA_W bits, so a truncated subtract is enough.
    logic                div_ge;
    logic [DATA_W-1:0]   div_sub;
    logic [2*DATA_W-1:0] div_next;

    assign div_ge   = acc_q[2*DATA_W-1:DATA_W-1] >= {1'b0, opnd_q};
    assign div_sub  = acc_q[2*DATA_W-2:DATA_W-1] - opnd_q;
    assign div_next = div_ge ? {div_sub, acc_q[DATA_W-2:0], 1'b1}
                             : {acc_q[2*DATA_W-2:0], 1'b0};

    // Sign-corrected result of the final iteration
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo, rem, fin_hi, fin_lo;

    assign prod_fix = neg_q ? -mul_next : mul_next;
    assign quo      = div_next[DATA_W-1:0];
    assign rem      = div_next[2*DATA_W-1:DATA_W];

    always_comb begin
        fin_hi = prod_fix[2*DATA_W-1:DATA_W];
        fin_lo = prod_fix[DATA_W-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                fin_hi = rs_q;
                fin_lo = '1;
            end else begin
                fin_hi = rem_neg_q ? -rem : rem;
                fin_lo = neg_q ? -quo : quo;
            end
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal gets its default value first, so no path through the
        // case leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        rs_d      = rs_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (is_start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    is_div_d  = i_funct[1];
                    neg_d     = rs_neg ^ rt_neg;
                    rem_neg_d = rs_neg;
                    div0_d    = (i_rt_reg == '0);
                    rs_d      = i_rs_reg;
                    if (i_funct[1]) begin
                        acc_d  = {{DATA_W{1'b0}}, rs_mag};
                        opnd_d = rt_mag;
                    end else begin
                        acc_d  = {{DATA_W{1'b0}}, rt_mag};
                        opnd_d = rs_mag;
                    end
                end else if (is_rtype && (i_funct == F_MTHI)) begin
                    hi_d = i_rs_reg;
                end else if (is_rtype && (i_funct == F_MTLO)) begin
                    lo_d = i_rs_reg;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before the edge.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            rs_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            rs_q      <= rs_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Outputs
    assign o_busy  = (state_q == S_RUN);
    assign o_stall = o_busy;
    assign o_done  = done_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

    always_comb begin
        o_mf_data = '0;
        if (i_funct == F_MFHI) o_mf_data = hi_q;
        else if (i_funct == F_MFLO) o_mf_data = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Directed bench for ex_muldiv_unit. Each start instruction pushes its expected
// HI/LO pair onto a scoreboard. The pair is popped and compared when o_done
// pulses. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [5:0]  i_op;
    logic [5:0]  i_funct;
    logic [31:0] i_rs_reg;
    logic [31:0] i_rt_reg;
    logic        o_busy;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_mf_data;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_op      (i_op),
        .i_funct   (i_funct),
        .i_rs_reg  (i_rs_reg),
        .i_rt_reg  (i_rt_reg),
        .o_busy    (o_busy),
        .o_stall   (o_stall),
        .o_done    (o_done),
        .o_mf_data (o_mf_data),
        .o_hi      (o_hi),
        .o_lo      (o_lo)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference HI:LO for a start instruction
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] rs,
                                          input logic [31:0] rt);
        logic [63:0] res;
        longint      sp;
        int          q, r;
        res = '0;
        case (f)
            F_MULT: begin
                sp  = longint'($signed(rs)) * longint'($signed(rt));
                res = sp;
            end
            F_MULTU: res = {32'h0, rs} * {32'h0, rt};
            F_DIV: begin
                if (rt == 32'h0) res = {rs, 32'hFFFF_FFFF};
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q   = $signed(rs) / $signed(rt);
                    r   = $signed(rs) % $signed(rt);
                    res = {r, q};
                end
            end
            F_DIVU: begin
                if (rt == 32'h0) res = {rs, 32'hFFFF_FFFF};
                else res = {rs % rt, rs / rt};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Present a start instruction for one clock. Optionally record its expected result.
    task automatic start_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                            input string tag, input logic [63:0] exp_v, input bit push);
        exp_t e;
        @(negedge clk);
        i_valid  = 1'b1;
        i_op     = 6'h00;
        i_funct  = f;
        i_rs_reg = rs;
        i_rt_reg = rt;
        if (push) begin
            e.tag = tag;
            e.hi  = exp_v[63:32];
            e.lo  = exp_v[31:0];
            sb.push_back(e);
        end
    endtask

    // Wait for o_done and count stall cycles. The caller may already have counted some.
    // Then pop the scoreboard and compare HI/LO.
    task automatic finish_op(input int pre_busy);
        int   busy;
        bit   seen;
        exp_t e;
        busy = pre_busy;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
            else if (o_stall) busy++;
            i_valid = 1'b0;
            i_funct = 6'h00;
        end
        check("scoreboard depth", sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.tag = "none";
            e.hi  = '0;
            e.lo  = '0;
        end
        check({e.tag, " done seen"}, seen, 1);
        check({e.tag, " stall cycles"}, busy, 32);
        check({e.tag, " hi"}, o_hi, e.hi);
        check({e.tag, " lo"}, o_lo, e.lo);
        @(negedge clk);
        check({e.tag, " done width"}, o_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pre;
        int          extra;
        logic [5:0]  rf;
        logic [31:0] ra, rb;
        logic [5:0]  functs [4];

        functs[0] = F_MULT;
        functs[1] = F_MULTU;
        functs[2] = F_DIV;
        functs[3] = F_DIVU;

        rst      = 1'b1;
        i_valid  = 1'b0;
        i_op     = 6'h00;
        i_funct  = 6'h00;
        i_rs_reg = '0;
        i_rt_reg = '0;
        repeat (3) @(negedge clk);
        check("reset busy",  o_busy,  0);
        check("reset stall", o_stall, 0);
        check("reset done",  o_done,  0);
        check("reset hi",    o_hi,    0);
        check("reset lo",    o_lo,    0);
        rst = 1'b0;

        // Signed and unsigned multiplies
        start_op(F_MULT, 32'hFFFF_FFFD, 32'd5, "mult -3*5", 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        finish_op(0);
        start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 64'hFFFF_FFFE_0000_0001, 1'b1);
        finish_op(0);

        // MF reads are combinational and do not depend on i_valid
        i_valid = 1'b1;
        i_funct = F_MFHI;
        #1 check("mfhi", o_mf_data, 32'hFFFF_FFFE);
        i_funct = F_MFLO;
        #1 check("mflo", o_mf_data, 32'h0000_0001);
        i_valid = 1'b0;
        i_funct = F_MFHI;
        #1 check("mfhi bubble", o_mf_data, 32'hFFFF_FFFE);
        i_funct = 6'h20;
        #1 check("mf other funct", o_mf_data, 32'h0);
        i_funct = 6'h00;

        // Divides, including the boundary cases
        start_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        finish_op(0);
        start_op(F_DIVU, 32'd7, 32'd0, "divu 7/0", 64'h0000_0007_FFFF_FFFF, 1'b1);
        finish_op(0);
        start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow", 64'h0000_0000_8000_0000, 1'b1);
        finish_op(0);
        start_op(F_DIV, 32'hFFFF_FF00, 32'd0, "div -256/0", 64'hFFFF_FF00_FFFF_FFFF, 1'b1);
        finish_op(0);

        // MTHI/MTLO while idle
        @(negedge clk);
        i_valid = 1'b1; i_funct = F_MTHI; i_rs_reg = 32'h1234_5678;
        @(negedge clk);
        check("mthi hi",    o_hi,    32'h1234_5678);
        check("mthi stall", o_stall, 0);
        check("mthi lo",    o_lo,    32'hFFFF_FFFF);
        i_valid = 1'b0; i_funct = F_MTLO; i_rs_reg = 32'hCAFE_F00D;
        @(negedge clk);
        check("mtlo bubble", o_lo, 32'hFFFF_FFFF);
        i_valid = 1'b1; i_op = 6'h23;
        @(negedge clk);
        check("mtlo non-rtype", o_lo, 32'hFFFF_FFFF);
        i_op = 6'h00; i_rs_reg = 32'hA5A5_A5A5;
        @(negedge clk);
        check("mtlo", o_lo, 32'hA5A5_A5A5);
        i_valid = 1'b0; i_funct = 6'h00;

        // Start and MT presented while busy are ignored
        start_op(F_MULT, 32'd3, 32'd4, "mult busy-ignore", 64'h0000_0000_0000_000C, 1'b1);
        @(negedge clk);
        pre = o_stall ? 1 : 0;
        i_valid = 1'b1; i_funct = F_MULT; i_rs_reg = 32'd100; i_rt_reg = 32'd100;
        @(negedge clk);
        pre += o_stall ? 1 : 0;
        i_funct = F_MTLO; i_rs_reg = 32'hDEAD_BEEF;
        finish_op(pre);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done) extra++;
        end
        check("busy-ignore extra done", extra, 0);
        check("busy-ignore lo kept", o_lo, 32'h0000_000C);
        check("busy-ignore hi kept", o_hi, 32'h0);

        // Reset in the middle of a divide
        @(negedge clk);
        i_valid = 1'b1; i_funct = F_MTHI; i_rs_reg = 32'h5555_AAAA;
        start_op(F_DIV, 32'd1000, 32'd7, "div aborted", 64'h0, 1'b0);
        @(negedge clk);
        i_valid = 1'b0; i_funct = 6'h00;
        repeat (9) @(negedge clk);
        check("div in flight", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy",  o_busy,  0);
        check("abort stall", o_stall, 0);
        check("abort done",  o_done,  0);
        check("abort hi",    o_hi,    0);
        check("abort lo",    o_lo,    0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done) extra++;
        end
        check("abort no done", extra, 0);

        start_op(F_MULT, 32'd6, 32'd7, "mult 6*7", 64'd42, 1'b1);
        finish_op(0);

        // A few random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rf = functs[i % 4];
            ra = $urandom;
            rb = (i >= 4) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            start_op(rf, ra, rb, $sformatf("rand%0d f=%0h", i, rf), model(rf, ra, rb), 1'b1);
            finish_op(0);
        end

        check("scoreboard empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register for the MIPS HI/LO instruction group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Runs an iterative 32-cycle multiply or divide and owns the HI/LO architectural registers.
- Raises a stall back to the IF/ID and ID/EX latches while an operation is in flight.
- Sits beside the ALU and reads the same latched operands: the op field, the sign-extended field and both register values.

Parameters:
- DATA_W, 32, operand width; HI and LO are DATA_W each.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  ID/EX entry is a real instruction, not a bubble (ID/EX stall flag low)
- i_op  in  6  latched opcode; unit acts only when 0x00
- i_funct  in  6  latched sig_extended[5:0]
- i_rs_reg  in  32  rs value: dividend, multiplicand, or MT source
- i_rt_reg  in  32  rt value: divisor or multiplier
- o_busy  out  1  iterative operation in progress
- o_stall  out  1  pipeline hold request
- o_done  out  1  one-cycle pulse when HI/LO are updated by mult/div
- o_mf_data  out  32  HI when funct=0x10, LO when funct=0x12, else 0
- o_hi  out  32  HI register
- o_lo  out  32  LO register

Behaviour:
- Reset: clk and rst are the names used throughout the codebase; reset is synchronous and active-high. On rst=1 at a rising edge: o_busy=0, o_done=0, HI=0, LO=0, counter=0, internal accumulators=0. Reset overrides everything, including mid-operation, which is abandoned with no HI/LO write.
- Funct decode when i_op=0x00:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU are "start" instructions.
  - 0x10 MFHI, 0x12 MFLO are "read" instructions.
  - 0x11 MTHI, 0x13 MTLO are "write" instructions.
  - All other functs: no effect.
- FSM has two states, IDLE and RUN.
- IDLE, i_valid & start:
  - Capture operands.
  - Signed ops convert operands to magnitudes and record result sign (quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs)).
  - Counter=0; go to RUN; o_busy=1 from the next cycle.
- IDLE, i_valid & MTHI / MTLO: HI or LO <= i_rs_reg at the edge. No stall.
- RUN: one iteration per cycle.
  - Multiply: shift-add, 64-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - After the DATA_W-th iteration: apply sign correction.
    - Multiply: HI:LO <= product.
    - Divide: LO <= quotient, HI <= remainder.
  - In the same edge: o_done=1 for one cycle, return to IDLE, o_busy=0.
- Latency: o_busy is high for exactly DATA_W (32) cycles. New HI/LO values are visible on the cycle o_done is high.
- o_stall = o_busy (combinational from the register). Holding the pipeline keeps the next instruction in ID/EX until completion, so MF and MT instructions never observe stale HI/LO.
- A start or MT presented while o_busy=1 is ignored. It is re-presented by the held pipeline.
- Divide by zero (rt=0), signed or unsigned: HI <= rs (original value), LO <= 0xFFFFFFFF. Same 32-cycle timing.
- Signed DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- o_mf_data is combinational from HI/LO and the funct field; it does not depend on i_valid.
- A start while i_valid=0 has no effect. Bubbles never start operations.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> o_stall high exactly 32 cycles; then o_done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MFHI -> o_mf_data=0xFFFFFFFE, MFLO -> 0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=7, rt=0 -> HI=7, LO=0xFFFFFFFF.
- MTHI rs=0x12345678 while idle -> HI updated next edge, o_stall stays 0. MTLO with i_valid=0 -> LO unchanged.
- Start MULT, then present a second MULT and an MTLO while busy -> both ignored; only the first result is written; exactly one o_done.
- rst=1 at iteration 10 of a DIV -> next cycle o_busy=0, o_stall=0, HI=LO=0, no o_done. A fresh MULT 6*7 afterwards -> LO=42, HI=0.
